// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one 128-bit BRAM port between two cache channels.
// Define MEM_ARB_PERF_CNT_EN to build the saturating grant/stall performance counters.
module mem_port_arbiter #(
  parameter int BRAM_LAT = 1,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [171:0]      req0_msg,
  input  logic              req0_val,
  output logic              req0_rdy,
  output logic [143:0]      resp0_msg,
  output logic              resp0_val,
  input  logic              resp0_rdy,
  input  logic [171:0]      req1_msg,
  input  logic              req1_val,
  output logic              req1_rdy,
  output logic [143:0]      resp1_msg,
  output logic              resp1_val,
  input  logic              resp1_rdy,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [127:0]      bram_din,
  input  logic [127:0]      bram_dout,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       stall_cnt0,
  output logic [15:0]       stall_cnt1
);

  localparam int         DATA_W    = 128;
  localparam int         ADDR_LSB  = 130;
  localparam logic [2:0] WAIT_INIT = 3'(BRAM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [143:0]        resp_msg_q, resp_msg_d;

  logic                grant;
  logic                fire;
  logic                resp_fire;
  logic [171:0]        win_msg;
  logic                unused_msg_bits;

  assign unused_msg_bits = ^{req0_msg, req1_msg};

  // Arbitration: a lone requester wins; under contention the one not granted last time wins.
  assign grant     = (req0_val & req1_val) ? ~last_grant_q : req1_val;
  assign fire      = (state_q == S_IDLE) & (req0_val | req1_val) & ~reset;
  assign req0_rdy  = fire & ~grant;
  assign req1_rdy  = fire & grant;
  assign win_msg   = grant ? req1_msg : req0_msg;
  assign resp_fire = (state_q == S_RESP) & (owner_q ? resp1_rdy : resp0_rdy);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    type_d       = type_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    resp_msg_d   = resp_msg_q;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          owner_d      = grant;
          last_grant_d = grant;
          type_d       = win_msg[171:170];
          addr_d       = win_msg[ADDR_LSB +: ADDR_W];
          data_d       = win_msg[DATA_W-1:0];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          // Types 2 and 3 behave as reads; only writes return zero data.
          resp_msg_d = {type_q, 14'b0, (type_q == 2'd1) ? {DATA_W{1'b0}} : bram_dout};
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (resp_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      type_q       <= 2'd0;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= 3'd0;
      resp_msg_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      resp_msg_q   <= resp_msg_d;
    end
  end

  assign bram_en   = (state_q == S_ISSUE);
  assign bram_we   = bram_en & (type_q == 2'd1);
  assign bram_addr = addr_q;
  assign bram_din  = data_q;
  assign resp0_msg = resp_msg_q;
  assign resp1_msg = resp_msg_q;
  assign resp0_val = (state_q == S_RESP) & ~owner_q;
  assign resp1_val = (state_q == S_RESP) & owner_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;
  logic [15:0] stall_cnt0_q, stall_cnt0_d;
  logic [15:0] stall_cnt1_q, stall_cnt1_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    grant_cnt0_d = sat_inc(grant_cnt0_q, req0_val & req0_rdy);
    grant_cnt1_d = sat_inc(grant_cnt1_q, req1_val & req1_rdy);
    stall_cnt0_d = sat_inc(stall_cnt0_q, req0_val & ~req0_rdy);
    stall_cnt1_d = sat_inc(stall_cnt1_q, req1_val & ~req1_rdy);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0_q <= 16'd0;
      grant_cnt1_q <= 16'd0;
      stall_cnt0_q <= 16'd0;
      stall_cnt1_q <= 16'd0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      stall_cnt0_q <= stall_cnt0_d;
      stall_cnt1_q <= stall_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign stall_cnt0 = stall_cnt0_q;
  assign stall_cnt1 = stall_cnt1_q;
`else
  assign grant_cnt0 = 16'd0;
  assign grant_cnt1 = 16'd0;
  assign stall_cnt0 = 16'd0;
  assign stall_cnt1 = 16'd0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for one port of the shared 128-bit data BRAM behind the blocking caches.
- Accepts val/rdy memory requests from two cache refill/writeback channels and grants round-robin.
- Drives the BRAM en/we/addr/din for exactly one cycle, waits the fixed BRAM read latency, and returns a val/rdy response to the granted requester.
- Replaces ad-hoc fixed-delay rdy/val generation around the BRAM.

Parameters:
- BRAM_LAT, 1, BRAM read latency in cycles from the en cycle to valid dout (legal range 1..7).
- ADDR_W, 10, BRAM address width; taken from req_msg[130+ADDR_W-1:130].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req0_msg  in  172  request: type[171:170] (0=read, 1=write), addr[139:130], data[127:0]
- req0_val  in  1  request 0 valid
- req0_rdy  out  1  request 0 accepted this cycle when val&rdy
- resp0_msg  out  144  response: {type[1:0], 14'b0, data[127:0]}
- resp0_val  out  1  response 0 valid
- resp0_rdy  in  1  response 0 consumed
- req1_msg, req1_val, req1_rdy, resp1_msg, resp1_val, resp1_rdy: same as channel 0
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_din  out  128  BRAM write data
- bram_dout  in  128  BRAM read data
- grant_cnt0, grant_cnt1  out  16  performance counters (see Optional Feature)
- stall_cnt0, stall_cnt1  out  16  performance counters (see Optional Feature)

Behaviour:
- Reset (async, active-high):
  - State IDLE; all rdy, resp_val, bram_en and bram_we are 0.
  - bram_addr, bram_din and resp_msg are 0.
  - last_grant = 1, so requester 0 wins the first conflict.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - grant = the single valid requester; if both are valid, the one != last_grant.
  - reqN_rdy = (state==IDLE) & (grant==N) & reqN_val. This is combinational; the other rdy is 0.
  - On fire: latch owner, type, addr, data; set last_grant = owner; go to ISSUE.
- ISSUE (1 cycle):
  - bram_en = 1; bram_we = (type==1); addr and din come from the latched values.
  - Type values 2 and 3 are treated as read.
  - Load wait counter with BRAM_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, capture bram_dout (reads only; writes capture 0) and go to RESP.
  - With BRAM_LAT=1, WAIT lasts exactly 1 cycle and dout is sampled in that cycle.
- RESP:
  - respN_val = 1 for the owner only; resp_msg is held stable while val=1 and rdy=0.
  - On val&rdy, go to IDLE; the next grant can fire in the same cycle IDLE is entered, not earlier.
- Latency: request fire at cycle t -> en at t+1 -> resp_val at t+1+BRAM_LAT+1.
  - Minimum occupancy: BRAM_LAT+3 cycles per transaction.
- Arbitration and exclusivity:
  - A requester holding val while losing simply waits; no starvation, because round-robin alternates under continuous contention.
  - At most one bram_en cycle per transaction; bram_en is never asserted outside ISSUE.
  - Only the owner's resp_val is ever asserted.
- Boundary cases:
  - Back-to-back requests from the same requester are allowed when the other is idle.
  - req_msg changing while not accepted is ignored.
  - Reset mid-transaction aborts immediately: pending response dropped, BRAM write not repeated.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - grant_cntN increments on each reqN fire.
  - stall_cntN increments each cycle reqN_val=1 and reqN_rdy=0.
  - All counters are 16-bit and saturate at 16'hFFFF; reset clears them to 0.
- Undefined: the four counter outputs are tied to 0 and no counter flops are built.

Test Plan:
- Single read, BRAM_LAT=1:
  - Stimulus: preload addr 10'h005=128'hA5..A5; req0 read addr 5 at cycle 2.
  - Response: bram_en=1, we=0 at cycle 3; resp0_val at cycle 5 with data A5..A5 and type 0.
- Write then read:
  - Stimulus: req1 write addr 10'h3FF data 128'h1234, then req1 read addr 3FF.
  - Response: write resp data 0; single we pulse; read returns 128'h1234.
- Conflict:
  - Stimulus: req0 and req1 both valid at reset release, continuously.
  - Response: grant order 0,1,0,1; each transaction 4 cycles apart for BRAM_LAT=1.
- Backpressure:
  - Stimulus: resp0_rdy=0 for 5 cycles.
  - Response: resp0_msg stable; no bram_en; req1_rdy=0 until resp0 fires.
- Latency parameter:
  - Stimulus: BRAM_LAT=3, read.
  - Response: resp_val 5 cycles after fire; dout sampled 3 cycles after en.
- Reset mid-WAIT:
  - Stimulus: assert reset during WAIT.
  - Response: outputs 0 immediately; next conflict grants req0; with MEM_ARB_PERF_CNT_EN, counters read 0.
